// File: rtl/l2_if_pkg.sv
// Shared constants and state encoding for the line-granular L1 <-> L2 request protocol.
// Imported by the L2 responder and by the L1 data cache controller.
package l2_if_pkg;
  localparam int WORD_BYTES  = 4;
  localparam int OFFSET_BITS = 6;
  localparam int BEATS       = (1 << OFFSET_BITS) / WORD_BYTES;

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} l2_state_e;
endpackage

// File: rtl/l2_line_responder_if.sv
// L1-facing line request port plus the word-wide memory beat bus of the L2 responder.
// master = L1 controller / memory side, slave = the responder.
interface l2_line_responder_if #(
  parameter int DATA_LENGTH = 32,
  parameter int LINE_SIZE   = 64
);
  logic                     l2_req;
  logic                     l2_we;
  logic [31:0]              l2_addr;
  logic [LINE_SIZE*8-1:0]   l2_write_data;
  logic [LINE_SIZE*8-1:0]   l2_read_data;
  logic                     l2_data_valid;
  logic                     l2_ready;
  logic                     mem_req;
  logic                     mem_we;
  logic [31:0]              mem_addr;
  logic [DATA_LENGTH-1:0]   mem_wdata;
  logic                     mem_gnt;
  logic [DATA_LENGTH-1:0]   mem_rdata;
  logic                     mem_rvalid;

  modport master (
    output l2_req, l2_we, l2_addr, l2_write_data, mem_gnt, mem_rdata, mem_rvalid,
    input  l2_read_data, l2_data_valid, l2_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  l2_req, l2_we, l2_addr, l2_write_data, mem_gnt, mem_rdata, mem_rvalid,
    output l2_read_data, l2_data_valid, l2_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/l2_beat_assembler.sv
// Line buffer: whole-line load for writebacks, indexed word write for refills, indexed word select.
// line_d_o/sel_o expose the post-update value so the caller can register it in the same cycle.
module l2_beat_assembler #(
  parameter int  DATA_LENGTH = 32,
  parameter int  LINE_SIZE   = 64,
  localparam int IW          = $clog2(LINE_SIZE * 8 / DATA_LENGTH)
) (
  input  logic                   clk,
  input  logic                   load_i,
  input  logic [LINE_SIZE*8-1:0] line_i,
  input  logic                   wr_i,
  input  logic [IW-1:0]          wr_idx_i,
  input  logic [DATA_LENGTH-1:0] wdata_i,
  input  logic [IW-1:0]          sel_idx_i,
  output logic [LINE_SIZE*8-1:0] line_d_o,
  output logic [DATA_LENGTH-1:0] sel_o
);
  logic [LINE_SIZE*8-1:0] line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (load_i) begin
      line_d = line_i;
    end else if (wr_i) begin
      line_d[int'(wr_idx_i) * DATA_LENGTH +: DATA_LENGTH] = wdata_i;
    end
  end

  assign line_d_o = line_d;
  assign sel_o    = line_d[int'(sel_idx_i) * DATA_LENGTH +: DATA_LENGTH];

  always_ff @(posedge clk) begin
    line_q <= line_d;
  end
endmodule

// File: rtl/l2_line_responder.sv
// L2-side responder: one line request at a time, serialized into granted word beats; reads
// reassembled in order. Completion is a single l2_data_valid pulse, BEATS+1 cycles at best.
module l2_line_responder
  import l2_if_pkg::*;
#(
  parameter int DATA_LENGTH     = WORD_BYTES * 8,
  parameter int LINE_SIZE       = BEATS * WORD_BYTES,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic               clk,
  input logic               rst,
  l2_line_responder_if.slave bus
);
  localparam int NB   = LINE_SIZE * 8 / DATA_LENGTH;
  localparam int OFFS = $clog2(LINE_SIZE);
  localparam int IW   = $clog2(NB);
  localparam int CW   = IW + 1;
  localparam int WBB  = $clog2(DATA_LENGTH / 8);

  l2_state_e              state_q;
  logic [CW-1:0]          issue_q, rx_q, issue_d, rx_d;
  logic [31-OFFS:0]       base_q;
  logic                   l2_ready_q, l2_data_valid_q, mem_req_q, mem_we_q;
  logic [31:0]            mem_addr_q, addr_next;
  logic [DATA_LENGTH-1:0] mem_wdata_q, sel_word;
  logic [LINE_SIZE*8-1:0] rdata_q, line_d;
  logic                   accept, fire, rx_ok, rd_req_d;

  assign accept = (state_q == IDLE) && bus.l2_req;
  assign fire   = mem_req_q && bus.mem_gnt;
  // A return in the grant cycle is legal even though rx has caught up with issue.
  assign rx_ok  = (state_q == RD) && bus.mem_rvalid && ((rx_q != issue_q) || fire);

  always_comb begin
    issue_d   = issue_q + CW'(fire);
    rx_d      = rx_q + CW'(rx_ok);
    rd_req_d  = (issue_d < CW'(NB)) && ((issue_d - rx_d) < CW'(MAX_OUTSTANDING));
    addr_next = {base_q, issue_d[IW-1:0], {WBB{1'b0}}};
  end

  l2_beat_assembler #(
    .DATA_LENGTH (DATA_LENGTH),
    .LINE_SIZE   (LINE_SIZE)
  ) u_asm (
    .clk       (clk),
    .load_i    (accept && bus.l2_we),
    .line_i    (bus.l2_write_data),
    .wr_i      (rx_ok),
    .wr_idx_i  (rx_q[IW-1:0]),
    .wdata_i   (bus.mem_rdata),
    .sel_idx_i (issue_d[IW-1:0]),
    .line_d_o  (line_d),
    .sel_o     (sel_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      l2_ready_q      <= 1'b1;
      l2_data_valid_q <= 1'b0;
      rdata_q         <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      issue_q         <= '0;
      rx_q            <= '0;
      base_q          <= '0;
    end else begin
      issue_q         <= issue_d;
      rx_q            <= rx_d;
      l2_data_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: if (accept) begin
          base_q      <= bus.l2_addr[31:OFFS];
          l2_ready_q  <= 1'b0;
          mem_req_q   <= 1'b1;
          mem_we_q    <= bus.l2_we;
          mem_addr_q  <= {bus.l2_addr[31:OFFS], {OFFS{1'b0}}};
          mem_wdata_q <= sel_word;
          state_q     <= bus.l2_we ? WR : RD;
        end
        WR: if (fire) begin
          if (issue_q == CW'(NB - 1)) begin
            mem_req_q       <= 1'b0;
            l2_data_valid_q <= 1'b1;
            state_q         <= RESP;
          end else begin
            mem_addr_q  <= addr_next;
            mem_wdata_q <= sel_word;
          end
        end
        RD: begin
          if (rx_d == CW'(NB)) begin
            mem_req_q       <= 1'b0;
            l2_data_valid_q <= 1'b1;
            rdata_q         <= line_d;
            state_q         <= RESP;
          end else begin
            mem_req_q <= rd_req_d;
            if (rd_req_d) mem_addr_q <= addr_next;
          end
        end
        RESP: begin
          l2_ready_q <= 1'b1;
          issue_q    <= '0;
          rx_q       <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.l2_ready      = l2_ready_q;
  assign bus.l2_data_valid = l2_data_valid_q;
  assign bus.l2_read_data  = rdata_q;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
endmodule

// File: tb/tb_l2_line_responder.sv
// Directed + randomized bench for l2_line_responder against a word-addressed memory model
// with configurable grant pattern and in-order read return latency.
module tb_l2_line_responder;
  import l2_if_pkg::*;

  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_line_responder_if #(.DATA_LENGTH(32), .LINE_SIZE(64)) bus ();

  l2_line_responder #(.DATA_LENGTH(32), .LINE_SIZE(64), .MAX_OUTSTANDING(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int ncyc     = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  // Stimulus knobs, written only by the main sequence.
  int          gnt_mode = 0;
  int          rlat     = 0;
  logic [31:0] seed     = 32'h0;

  // Memory model state, written only by the memory process.
  logic [31:0] wmem [logic [31:0]];
  logic [31:0] rq_dat [$];
  int          rq_due [$];
  logic        log_we [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_dat [$];
  int granted_rd = 0, returned = 0, maxout = 0, stab_err = 0;
  int nvalid = 0, last_gnt = 0, last_valid = 0;
  bit tog = 1'b1, held = 1'b0;
  logic [31:0] held_addr, held_dat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    if (seed == 32'h0) return (a >> 2) + 32'h0000_0BF0;
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  function automatic logic [511:0] exp_line(input logic [31:0] a);
    logic [511:0] l;
    logic [31:0]  b;
    b = a & ~32'h3F;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = mem_word(b + 32'(4 * i));
    return l;
  endfunction

  always @(negedge clk) begin
    bit g;
    int o;
    case (gnt_mode)
      0:       g = 1'b1;
      1:       g = tog;
      default: g = ($urandom_range(0, 3) != 0);
    endcase
    tog = ~tog;
    bus.mem_gnt    = g;
    bus.mem_rvalid = 1'b0;
    if (held && bus.mem_req &&
        (bus.mem_addr !== held_addr || (bus.mem_we && bus.mem_wdata !== held_dat)))
      stab_err++;
    held      = bus.mem_req && !g;
    held_addr = bus.mem_addr;
    held_dat  = bus.mem_wdata;
    if (bus.mem_req && g) begin
      last_gnt = ncyc;
      log_we.push_back(bus.mem_we);
      log_addr.push_back(bus.mem_addr);
      log_dat.push_back(bus.mem_wdata);
      if (bus.mem_we) begin
        wmem[bus.mem_addr] = bus.mem_wdata;
      end else begin
        rq_dat.push_back(mem_word(bus.mem_addr));
        rq_due.push_back(ncyc + rlat);
        granted_rd++;
      end
    end
    if (rq_due.size() > 0 && rq_due[0] <= ncyc) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rq_dat.pop_front();
      void'(rq_due.pop_front());
      returned++;
    end
    o = granted_rd - returned;
    if (o > maxout) maxout = o;
    if (bus.l2_data_valid === 1'b1) begin
      nvalid++;
      last_valid = ncyc;
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  512'(bus.l2_ready), 512'(1));
    chk({tag, "_valid"},  512'(bus.l2_data_valid), 512'(0));
    chk({tag, "_rdata"},  bus.l2_read_data, 512'(0));
    chk({tag, "_mreq"},   512'(bus.mem_req), 512'(0));
    chk({tag, "_mwe"},    512'(bus.mem_we), 512'(0));
    chk({tag, "_maddr"},  512'(bus.mem_addr), 512'(0));
    chk({tag, "_mwdata"}, 512'(bus.mem_wdata), 512'(0));
  endtask

  // Called just after a falling edge; returns at the falling edge of the l2_data_valid cycle.
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [511:0] wl,
                         input int inj_k, output int lat, output logic [511:0] rl,
                         output int ready_bad);
    bus.l2_req = 1'b1; bus.l2_we = we; bus.l2_addr = addr; bus.l2_write_data = wl;
    lat = -1; rl = '0; ready_bad = 0;
    for (int k = 1; k <= 600 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) bus.l2_req = 1'b0;
      if (k == inj_k) begin
        bus.l2_req = 1'b1; bus.l2_we = 1'b1; bus.l2_addr = 32'h0000_5000; bus.l2_write_data = '1;
      end
      if (k == inj_k + 1) bus.l2_req = 1'b0;
      if (bus.l2_ready !== 1'b0) ready_bad++;
      if (bus.l2_data_valid === 1'b1) begin
        lat = k;
        rl  = bus.l2_read_data;
      end
    end
  endtask

  initial begin
    logic [511:0] exp, rl, prev, wl;
    logic [31:0]  a;
    int lat, rb, v0, l0, s0, r0, bad, nw;
    bit found;

    rst = 1'b1;
    bus.l2_req = 1'b0; bus.l2_we = 1'b0; bus.l2_addr = '0; bus.l2_write_data = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Refill with same-cycle returns and an unaligned request address.
    exp = exp_line(32'h0000_1067);
    l0 = log_addr.size(); v0 = nvalid;
    run_req(1'b0, 32'h0000_1067, '0, 0, lat, rl, rb);
    chk("t1_latency", 512'(lat), 512'(17));
    chk("t1_line", rl, exp);
    chk("t1_ready_low", 512'(rb), 512'(0));
    @(negedge clk);
    chk("t1_ready_after", 512'(bus.l2_ready), 512'(1));
    #1;
    chk("t1_valid_count", 512'(nvalid - v0), 512'(1));
    chk("t1_beats", 512'(log_addr.size() - l0), 512'(16));
    for (int i = 0; i < 16 && l0 + i < log_addr.size(); i++)
      chk($sformatf("t1_addr%0d", i), 512'(log_addr[l0 + i]), 512'(32'h1040 + 4 * i));
    prev = rl;

    // Writeback with a toggling grant.
    gnt_mode = 1;
    for (int i = 0; i < 16; i++) wl[i*32 +: 32] = 32'hA000_0000 + i;
    l0 = log_addr.size(); v0 = nvalid; s0 = stab_err;
    run_req(1'b1, 32'h0000_2000, wl, 0, lat, rl, rb);
    chk("t2_rdata_at_valid", rl, prev);
    chk("t2_ready_low", 512'(rb), 512'(0));
    @(negedge clk);
    chk("t2_ready_after", 512'(bus.l2_ready), 512'(1));
    #1;
    chk("t2_valid_after_last_gnt", 512'(last_valid), 512'(last_gnt + 1));
    chk("t2_valid_count", 512'(nvalid - v0), 512'(1));
    chk("t2_beats", 512'(log_addr.size() - l0), 512'(16));
    for (int i = 0; i < 16 && l0 + i < log_addr.size(); i++)
      chk($sformatf("t2_beat%0d", i), 512'({log_we[l0 + i], log_addr[l0 + i], log_dat[l0 + i]}),
          512'({1'b1, 32'h2000 + 32'(4 * i), 32'hA000_0000 + 32'(i)}));
    chk("t2_beat_stable", 512'(stab_err - s0), 512'(0));
    chk("t2_rdata_kept", bus.l2_read_data, prev);

    // Refill with return latency 5: the outstanding limit must be reached but never exceeded.
    gnt_mode = 0; rlat = 5; seed = $urandom | 32'h1;
    a = 32'h0004_0000 + (32'($urandom_range(0, 255)) << 6) + 32'($urandom_range(0, 63));
    exp = exp_line(a); v0 = nvalid;
    run_req(1'b0, a, '0, 0, lat, rl, rb);
    chk("t3_line", rl, exp);
    chk("t3_ready_low", 512'(rb), 512'(0));
    @(negedge clk);
    #1;
    chk("t3_valid_count", 512'(nvalid - v0), 512'(1));
    chk("t3_max_outstanding", 512'(maxout), 512'(MAXO));

    // A writeback strobe arriving mid-refill must be ignored.
    gnt_mode = 2; rlat = 2;
    exp = exp_line(32'h0000_9024);
    l0 = log_we.size(); v0 = nvalid;
    run_req(1'b0, 32'h0000_9024, '0, 5, lat, rl, rb);
    chk("t4_line", rl, exp);
    @(negedge clk);
    chk("t4_ready_after", 512'(bus.l2_ready), 512'(1));
    #1;
    nw = 0;
    for (int i = l0; i < log_we.size(); i++) if (log_we[i]) nw++;
    chk("t4_no_write_beats", 512'(nw), 512'(0));
    chk("t4_valid_count", 512'(nvalid - v0), 512'(1));
    chk("t4_no_write_mem", 512'(wmem.exists(32'h0000_5000)), 512'(0));
    exp = exp_line(32'h0000_A000);
    run_req(1'b0, 32'h0000_A000, '0, 0, lat, rl, rb);
    chk("t4_next_line", rl, exp);
    @(negedge clk);

    // Reset after seven returned beats aborts the refill; late returns are ignored.
    gnt_mode = 0; rlat = 3; r0 = returned; found = 1'b0;
    bus.l2_req = 1'b1; bus.l2_we = 1'b0; bus.l2_addr = 32'h0000_6000;
    for (int k = 1; k <= 100 && !found; k++) begin
      @(negedge clk);
      if (k == 1) bus.l2_req = 1'b0;
      #1;
      if (returned - r0 >= 7) found = 1'b1;
    end
    chk("t5_seven_beats_seen", 512'(found), 512'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("t5_reset");
    v0 = nvalid; bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.mem_req !== 1'b0 || bus.l2_data_valid !== 1'b0 || bus.l2_ready !== 1'b1) bad++;
    end
    #1;
    chk("t5_quiet_after_reset", 512'(bad), 512'(0));
    chk("t5_no_valid", 512'(nvalid - v0), 512'(0));
    chk("t5_returns_drained", 512'(rq_due.size()), 512'(0));
    exp = exp_line(32'h0000_3000);
    run_req(1'b0, 32'h0000_3000, '0, 0, lat, rl, rb);
    chk("t5_fresh_line", rl, exp);
    @(negedge clk);
    chk("t5_ready_after", 512'(bus.l2_ready), 512'(1));

    // Back-to-back writeback then refill of the same line, plus randomized repeats.
    for (int it = 0; it < 5; it++) begin
      gnt_mode = 2; rlat = $urandom_range(0, 6);
      a = 32'h0008_0000 + (32'(it) << 12) + 32'($urandom_range(0, 63));
      for (int i = 0; i < 16; i++) wl[i*32 +: 32] = $urandom;
      prev = bus.l2_read_data; v0 = nvalid;
      run_req(1'b1, a, wl, 0, lat, rl, rb);
      chk($sformatf("t6_wr_rdata_kept%0d", it), rl, prev);
      chk($sformatf("t6_wr_ready_low%0d", it), 512'(rb), 512'(0));
      @(negedge clk);
      chk($sformatf("t6_ready_rise%0d", it), 512'(bus.l2_ready), 512'(1));
      @(negedge clk);
      run_req(1'b0, a, '0, 0, lat, rl, rb);
      chk($sformatf("t6_readback%0d", it), rl, wl);
      chk($sformatf("t6_rd_min_latency%0d", it), 512'(lat >= 17), 512'(1));
      @(negedge clk);
      #1;
      chk($sformatf("t6_two_valids%0d", it), 512'(nvalid - v0), 512'(2));
    end
    chk("stability_overall", 512'(stab_err), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/l2_line_responder.md
Name: l2_line_responder

Overview:
- Responder (L2 side) of the line-granular l2_req/l2_we/l2_addr/l2_write_data / l2_read_data/l2_data_valid/l2_ready protocol driven by the L1 data cache controller.
- Accepts one whole-line writeback or refill request at a time.
- Serializes the line into DATA_LENGTH-wide beats on a word-wide memory bus with a grant handshake; reassembles read beats into a line.
- Signals completion of either request type with a single l2_data_valid pulse.

Parameters:
- DATA_LENGTH, 32, memory bus word width in bits; must be 32.
- LINE_SIZE, 64, line size in bytes.
- MAX_OUTSTANDING, 4, maximum read beats granted but not yet returned (1..BEATS).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- l2_req  in  1  one-cycle request strobe from L1.
- l2_we  in  1  1 = line write (writeback), 0 = line read (refill).
- l2_addr  in  32  line address; offset bits are ignored.
- l2_write_data  in  LINE_SIZE*8  writeback line.
- l2_read_data  out  LINE_SIZE*8  refill line; valid when l2_data_valid=1 and the request was a read.
- l2_data_valid  out  1  one-cycle completion pulse.
- l2_ready  out  1  high only when IDLE and able to accept a request.
- mem_req  out  1  beat request.
- mem_we  out  1  beat is a write.
- mem_addr  out  32  byte address of the beat.
- mem_wdata  out  DATA_LENGTH  write beat data.
- mem_gnt  in  1  beat accepted when mem_req && mem_gnt.
- mem_rdata  in  DATA_LENGTH  read return data.
- mem_rvalid  in  1  read return strobe; returns arrive in issue order, at the earliest in the cycle of the grant.

Behaviour:
- Constants: BEATS = LINE_SIZE*8/DATA_LENGTH (16); OFFSET_BITS = log2(LINE_SIZE).
- Beat i occupies bits [32i+31:32i] of the line.
- Beat address: mem_addr = {base[31:OFFSET_BITS], i, 2'b00}, where base is l2_addr with offset bits zeroed.
- Reset values (sync, rst=1): state IDLE; l2_ready=1; l2_data_valid=0; l2_read_data=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; all counters 0.
- Reset mid-operation aborts the transfer: no l2_data_valid is issued and no further mem_req. Returns arriving after reset are ignored.
- States: IDLE, WR, RD, RESP.
- IDLE:
  - l2_ready=1.
  - On l2_req: latch base, l2_we and l2_write_data; deassert l2_ready the next cycle; go to WR (we=1) or RD (we=0).
  - mem_rvalid is ignored in IDLE.
- WR:
  - mem_req=1, mem_we=1, mem_wdata = beat issue_cnt, mem_addr per issue_cnt.
  - Each grant increments issue_cnt.
  - The grant of beat BEATS-1 moves to RESP.
  - mem_rvalid is ignored.
- RD:
  - mem_req=1, mem_we=0 while issue_cnt<BEATS and (issue_cnt-rx_cnt)<MAX_OUTSTANDING; otherwise mem_req=0.
  - Each grant increments issue_cnt.
  - Each mem_rvalid writes mem_rdata into buffer word rx_cnt and increments rx_cnt.
  - A grant and an rvalid in the same cycle update both counters.
  - When rx_cnt reaches BEATS (last rvalid cycle), move to RESP.
  - mem_rvalid with rx_cnt already equal to issue_cnt is a protocol error and is dropped.
- RESP:
  - l2_data_valid=1 for exactly one cycle.
  - On reads, l2_read_data holds the assembled line from this cycle until the next read completes.
  - On writes, l2_read_data is unchanged.
  - Next cycle: IDLE, l2_ready=1.
- l2_req while l2_ready=0 is ignored: no latch, no effect on the current transfer.
- Minimum latency from accept to l2_data_valid: BEATS+1 cycles for writes, and for reads with same-cycle return.
- Counters are OFFSET_BITS-2+1 bits wide so they can reach BEATS without wrapping.
- mem_addr never crosses the line boundary.

Decomposition:
- Shared package l2_if_pkg: state enum (IDLE/WR/RD/RESP), BEATS, OFFSET_BITS, WORD_BYTES.
- The L1 controller imports the same package.
- One sub-module: l2_beat_assembler. It is the LINE_SIZE*8-bit buffer with indexed word write (read path) and indexed word select (write path, mem_wdata mux).

Test Plan:
- Read at l2_addr=0x0000_1067, memory word at 0x1040+4i = 0x1000+i, gnt always 1, same-cycle rvalid -> mem_addr sequence 0x1040..0x107C; one l2_data_valid 17 cycles after accept; l2_read_data word i = 0x1000+i; l2_ready low throughout, high the cycle after.
- Write at 0x0000_2000, line word i = 0xA000_0000+i, mem_gnt toggling 1,0,1,0 -> 16 writes to 0x2000..0x203C with matching data, each beat held stable until granted; one l2_data_valid after the last grant; l2_read_data unchanged.
- Read with rvalid latency 5 and MAX_OUTSTANDING=4 -> never more than 4 beats granted but not yet returned; mem_req drops while the limit is hit; line assembled in order; single l2_data_valid.
- Second l2_req (we=1, different address) pulsed mid-read -> ignored; the read completes correctly; no extra l2_data_valid; next request is accepted only after l2_ready returns high.
- rst asserted for 1 cycle after 7 read beats -> next cycle all outputs at reset values with l2_ready=1; late mem_rvalid pulses ignored; a fresh read at 0x3000 completes with correct data.
- Back-to-back: write completes, L1 issues read the cycle after l2_ready rises -> accepted; read data correct; exactly two l2_data_valid pulses in total.
